// File: rtl/fadd_pkg.sv
// Shared types and helpers for the fadd scheduler.
//  - Float format constants for single and double precision.
//  - tag_t: {valid, requester id} carried through the tag pipe. The id field
//    is sized for the largest supported requester count (8).
//  - rr_pick: round-robin one-hot pick among eligible requesters, starting
//    at ptr and wrapping from nreq-1 to 0.
package fadd_pkg;

    localparam int NREQ_MAX = 8;
    localparam int ID_W     = 3;

    localparam int EXP_LEN_SP = 8;
    localparam int MAN_SP     = 23;
    localparam int BIAS_SP    = 127;
    localparam int EXP_LEN_DP = 11;
    localparam int MAN_DP     = 52;
    localparam int BIAS_DP    = 1023;

    function automatic int exp_len(input int n);
        return (n == 64) ? EXP_LEN_DP : EXP_LEN_SP;
    endfunction

    function automatic int man(input int n);
        return (n == 64) ? MAN_DP : MAN_SP;
    endfunction

    function automatic int bias(input int n);
        return (n == 64) ? BIAS_DP : BIAS_SP;
    endfunction

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] elig,
        input logic [ID_W-1:0]     ptr,
        input int                  nreq
    );
        logic [NREQ_MAX-1:0] g;
        logic                found;
        int                  idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            idx = (int'(ptr) + k) % nreq;
            if (k < nreq && !found && elig[idx[ID_W-1:0]]) begin
                g[idx[ID_W-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/fadd_sched_rr_arb.sv
// Combinational round-robin arbiter.
//  elig  : eligible requesters
//  ptr   : search start (highest priority this cycle)
//  grant : one-hot winner, zero when nothing is eligible
//  idx   : binary index of the winner (0 when none)
//  any   : some requester won
// The pointer register lives in the parent.
module rr_arb
    import fadd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [NREQ_MAX-1:0] g_x;

    assign g_x   = rr_pick(NREQ_MAX'(elig), ID_W'(ptr), NREQ);
    assign grant = g_x[NREQ-1:0];
    // Upper bits of g_x are always zero; reducing the full vector is harmless.
    assign any   = |g_x;

    always_comb begin
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/fadd_sched.sv
// Round-robin scheduler sharing one fadd datapath between NREQ requesters.
//  clk, rst_n   : clock, asynchronous active-low reset
//  req_valid/a/b: per-requester operand port
//  req_ready    : one-hot accept strobe
//  resp_valid/data/ack : per-requester result slot, held until acked
//  fa_a, fa_b   : registered operands to the external fadd
//  fa_out       : fadd result, sampled LAT cycles after fa_a/fa_b update
//  issue_cnt    : accepted operations, wraps at 2^16
// Each requester may have only one operation outstanding (busy), so a
// returning result always finds its slot empty.
module fadd_sched
    import fadd_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0][N-1:0]   req_a,
    input  logic [NREQ-1:0][N-1:0]   req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          resp_valid,
    output logic [NREQ-1:0][N-1:0]   resp_data,
    input  logic [NREQ-1:0]          resp_ack,
    output logic [N-1:0]             fa_a,
    output logic [N-1:0]             fa_b,
    input  logic [N-1:0]             fa_out,
    output logic [15:0]              issue_cnt
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]  busy;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  ack_take;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    win;
    logic             win_any;
    tag_t [LAT-1:0]   tag_pipe;
    tag_t             tag_last;

    assign elig = req_valid & ~busy;

    rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .elig  (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win),
        .any   (win_any)
    );

    // Grant only ever covers valid requesters, so grant itself is the accept.
    // Held low during reset so nothing looks accepted while state is cleared.
    assign req_ready = rst_n ? grant : '0;
    assign ack_take  = resp_valid & resp_ack;
    assign tag_last  = tag_pipe[LAT-1];

    // Issue: pointer advance, operand capture, accept count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            fa_a      <= '0;
            fa_b      <= '0;
            issue_cnt <= '0;
        end else if (win_any) begin
            rr_ptr    <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
            fa_a      <= req_a[win];
            fa_b      <= req_b[win];
            issue_cnt <= issue_cnt + 16'd1;
        end
    end

    // Tag pipe: free-running shift, one stage per fadd cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= '{v: win_any, id: ID_W'(win)};
            for (int s = 1; s < LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    // Result slots and busy flags. A delivery and an ack for the same slot
    // cannot coincide: the slot is empty until its single in-flight op lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= '0;
            resp_data  <= '0;
            busy       <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (tag_last.v && tag_last.id == ID_W'(i)) begin
                    resp_valid[i] <= 1'b1;
                    resp_data[i]  <= fa_out;
                end else if (ack_take[i]) begin
                    resp_valid[i] <= 1'b0;
                end
                if (grant[i])         busy[i] <= 1'b1;
                else if (ack_take[i]) busy[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fadd_sched.sv
module tb_fadd_sched;

    localparam int N  = 32;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // LAT=1 instance
    logic [NR-1:0]        v1, ack1, rdy1, rv1;
    logic [NR-1:0][N-1:0] a1, b1, rd1;
    logic [N-1:0]         fa1a, fa1b, fo1;
    logic [15:0]          cnt1;
    // LAT=3 instance
    logic [NR-1:0]        v3, ack3, rdy3, rv3;
    logic [NR-1:0][N-1:0] a3, b3, rd3;
    logic [N-1:0]         fa3a, fa3b, fo3, p1, p2;
    logic [15:0]          cnt3;

    int tests = 0;
    int fails = 0;

    fadd_sched #(.N(N), .NREQ(NR), .LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_a(a1), .req_b(b1),
        .req_ready(rdy1), .resp_valid(rv1), .resp_data(rd1), .resp_ack(ack1),
        .fa_a(fa1a), .fa_b(fa1b), .fa_out(fo1), .issue_cnt(cnt1));

    fadd_sched #(.N(N), .NREQ(NR), .LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_a(a3), .req_b(b3),
        .req_ready(rdy3), .resp_valid(rv3), .resp_data(rd3), .resp_ack(ack3),
        .fa_a(fa3a), .fa_b(fa3b), .fa_out(fo3), .issue_cnt(cnt3));

    // Behavioural single-precision fadd (via double-precision reals).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:23] == 8'h00)      d = {f[31], 63'b0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'b0};
        else begin
            e = 11'(int'(f[30:23]) - 127 + 1023);
            d = {f[31], e, f[22:0], 29'b0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [7:0]  e;
        d = $realtobits(r);
        if (d[62:52] == 11'h000) return {d[63], 31'b0};
        if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
        e = 8'(int'(d[62:52]) - 1023 + 127);
        return {d[63], e, d[51:29]};
    endfunction

    function automatic logic [31:0] fadd_bits(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] i2f(input int x);
        return r2f(real'(x));
    endfunction

    always_comb fo1 = fadd_bits(fa1a, fa1b);
    always @(posedge clk) begin
        p1 <= fadd_bits(fa3a, fa3b);
        p2 <= p1;
    end
    assign fo3 = p2;

    // Reference model for the LAT=1 instance.
    typedef struct {
        int          id;
        logic [31:0] d;
        int          due;
    } fl_t;
    fl_t         q[$];
    bit          m_busy[NR];
    bit          m_rv[NR];
    logic [31:0] m_rd[NR];
    int          m_rr, m_cnt, edge_n;
    int          ia[NR], ib[NR];

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_busy[i] = 1'b0; m_rv[i] = 1'b0; m_rd[i] = '0;
        end
        m_rr = 0; m_cnt = 0; q.delete();
    endtask

    task automatic set_op(input int i, input int x, input int y);
        ia[i] = x; ib[i] = y;
        a1[i] = i2f(x); b1[i] = i2f(y);
    endtask

    task automatic rand_op(input int i);
        set_op(i, int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000)));
    endtask

    // One cycle: check at negedge against the model, advance model at posedge.
    task automatic step(output int w, output logic [NR-1:0] g);
        logic [NR-1:0] exp_rdy, exp_rv;
        int idx;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_rr + k) % NR;
            if (w < 0 && v1[idx] && !m_busy[idx]) w = idx;
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        for (int i = 0; i < NR; i++) exp_rv[i] = m_rv[i];
        g = rdy1;
        tests++;
        if (rdy1 !== exp_rdy) begin
            fails++; $display("FAIL req_ready: got %b want %b (t=%0t)", rdy1, exp_rdy, $time);
        end
        tests++;
        if (rv1 !== exp_rv) begin
            fails++; $display("FAIL resp_valid: got %b want %b (t=%0t)", rv1, exp_rv, $time);
        end
        tests++;
        if (cnt1 !== 16'(m_cnt)) begin
            fails++; $display("FAIL issue_cnt: got %0d want %0d (t=%0t)", cnt1, m_cnt, $time);
        end
        for (int i = 0; i < NR; i++) begin
            if (m_rv[i]) begin
                tests++;
                if (rd1[i] !== m_rd[i]) begin
                    fails++; $display("FAIL resp_data[%0d]: got %h want %h (t=%0t)", i, rd1[i], m_rd[i], $time);
                end
            end
        end
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < NR; i++) begin
            if (m_rv[i] && ack1[i]) begin m_rv[i] = 1'b0; m_busy[i] = 1'b0; end
        end
        if (w >= 0) begin
            q.push_back('{w, i2f(ia[w] + ib[w]), edge_n + 1});
            m_busy[w] = 1'b1;
            m_rr  = (w + 1) % NR;
            m_cnt = (m_cnt + 1) % 65536;
        end
        while (q.size() > 0 && q[0].due == edge_n) begin
            m_rv[q[0].id] = 1'b1;
            m_rd[q[0].id] = q[0].d;
            void'(q.pop_front());
        end
        #1;
        if (w >= 0) rand_op(w);
    endtask

    task automatic drain();
        int w; logic [NR-1:0] g;
        v1 = '0; ack1 = '1;
        for (int k = 0; k < 4; k++) step(w, g);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests++; if (rv1 !== '0)   begin fails++; $display("FAIL reset_resp_valid: got %b want 0", rv1); end
        tests++; if (rdy1 !== '0)  begin fails++; $display("FAIL reset_req_ready: got %b want 0", rdy1); end
        tests++; if (cnt1 !== '0)  begin fails++; $display("FAIL reset_issue_cnt: got %0d want 0", cnt1); end
        tests++; if (fa1a !== '0 || fa1b !== '0) begin fails++; $display("FAIL reset_fa: got %h/%h want 0", fa1a, fa1b); end
        tests++; if (rd1 !== '0)   begin fails++; $display("FAIL reset_resp_data: got %h want 0", rd1); end
        tests++; if (rv3 !== '0 || cnt3 !== '0) begin fails++; $display("FAIL reset_lat3: rv %b cnt %0d want 0", rv3, cnt3); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int w; logic [NR-1:0] g;
        v1 = 4'b0001; ack1 = '0;
        set_op(0, 1, 2);
        tests++; if (a1[0] !== 32'h3F800000) begin fails++; $display("FAIL single_operand_enc: got %h want 3f800000", a1[0]); end
        step(w, g);
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", g); end
        v1 = '0;
        tests++; if (rv1[0] !== 1'b0) begin fails++; $display("FAIL single_early: got %b want 0", rv1[0]); end
        step(w, g);
        step(w, g);
        tests++; if (rv1[0] !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", rv1[0]); end
        tests++; if (rd1[0] !== 32'h40400000) begin fails++; $display("FAIL single_data: got %h want 40400000", rd1[0]); end
        ack1 = 4'b0001;
        step(w, g);
        drain();
    endtask

    task automatic test_rotation();
        int w, prev, acc; logic [NR-1:0] g;
        for (int i = 0; i < NR; i++) rand_op(i);
        v1 = '1; ack1 = '1; prev = -1; acc = 0;
        for (int k = 0; k < 24; k++) begin
            step(w, g);
            if (w >= 0) begin
                acc++;
                if (prev >= 0) begin
                    tests++;
                    if (w !== (prev + 1) % NR) begin
                        fails++; $display("FAIL rotation: got %0d want %0d", w, (prev + 1) % NR);
                    end
                end
                prev = w;
            end
        end
        tests++; if (acc !== 24) begin fails++; $display("FAIL rotation_throughput: got %0d want 24", acc); end
        drain();
    endtask

    task automatic test_hold();
        int w, n2; logic [NR-1:0] g;
        v1 = '1; ack1 = 4'b1011; n2 = 0;
        for (int k = 0; k < 16; k++) begin
            step(w, g);
            if (w == 2) n2++;
        end
        tests++; if (n2 !== 1) begin fails++; $display("FAIL hold_grants2: got %0d want 1", n2); end
        tests++; if (rv1[2] !== 1'b1) begin fails++; $display("FAIL hold_valid2: got %b want 1", rv1[2]); end
        ack1 = '1;
        step(w, g);
        tests++; if (g[2] !== 1'b0) begin fails++; $display("FAIL hold_ack_cycle_ready2: got %b want 0", g[2]); end
        for (int k = 0; k < 4; k++) step(w, g);
        drain();
    endtask

    task automatic test_wrap();
        int w; logic [NR-1:0] g;
        rand_op(0); rand_op(2);
        v1 = 4'b0100; ack1 = '1;
        step(w, g);
        tests++; if (g !== 4'b0100) begin fails++; $display("FAIL wrap_setup: got %b want 0100", g); end
        drain();
        v1 = 4'b0101;
        step(w, g);
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL wrap_grant: got %b want 0001", g); end
        step(w, g);
        tests++; if (g !== 4'b0100) begin fails++; $display("FAIL wrap_next: got %b want 0100", g); end
        drain();
    endtask

    task automatic test_reset_mid();
        int w; logic [NR-1:0] g;
        v1 = '1; ack1 = '1;
        for (int k = 0; k < 3; k++) step(w, g);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (rv1 !== '0)  begin fails++; $display("FAIL midreset_resp_valid: got %b want 0", rv1); end
        tests++; if (cnt1 !== '0) begin fails++; $display("FAIL midreset_issue_cnt: got %0d want 0", cnt1); end
        tests++; if (rdy1 !== '0) begin fails++; $display("FAIL midreset_req_ready: got %b want 0", rdy1); end
        v1 = '0;
        model_reset();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step(w, g);
    endtask

    task automatic test_lat3();
        int gord[$], rord[$];
        logic [NR-1:0] g;
        bit seen[NR];
        logic [31:0] want;
        ack3 = '0;
        v3 = 4'b0001; a3[0] = 32'h7F800000; b3[0] = 32'h3F800000;
        @(negedge clk);
        tests++; if (rdy3 !== 4'b0001) begin fails++; $display("FAIL lat3_grant: got %b want 0001", rdy3); end
        @(posedge clk); #1; v3 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (rv3[0] !== (k == 3)) begin fails++; $display("FAIL lat3_timing k=%0d: got %b want %b", k, rv3[0], (k == 3)); end
        end
        tests++; if (rd3[0] !== 32'h7F800000) begin fails++; $display("FAIL lat3_inf: got %h want 7f800000", rd3[0]); end
        ack3 = 4'b0001;
        @(posedge clk); #1; ack3 = '0;
        // back-to-back from requesters 0 and 1 (pointer now at 1)
        for (int i = 0; i < NR; i++) seen[i] = 1'b0;
        a3[0] = i2f(3); b3[0] = i2f(4);
        a3[1] = i2f(5); b3[1] = i2f(6);
        v3 = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            g = rdy3;
            for (int i = 0; i < 2; i++) begin
                if (rv3[i] && !seen[i]) begin seen[i] = 1'b1; rord.push_back(i); end
            end
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) if (g[i]) begin v3[i] = 1'b0; gord.push_back(i); end
        end
        tests++;
        if (gord.size() != 2 || rord.size() != 2) begin
            fails++; $display("FAIL lat3_b2b_count: got %0d grants %0d resps want 2/2", gord.size(), rord.size());
        end else begin
            tests++; if (gord[0] != 1) begin fails++; $display("FAIL lat3_b2b_first_grant: got %0d want 1", gord[0]); end
            tests++; if (rord[0] != gord[0] || rord[1] != gord[1]) begin
                fails++; $display("FAIL lat3_b2b_order: got %0d,%0d want %0d,%0d", rord[0], rord[1], gord[0], gord[1]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            want = (i == 0) ? 32'h40E00000 : 32'h41300000;
            tests++; if (rd3[i] !== want) begin fails++; $display("FAIL lat3_b2b_data[%0d]: got %h want %h", i, rd3[i], want); end
        end
        ack3 = '1;
        @(posedge clk); #1; ack3 = '0;
    endtask

    initial begin
        v1 = '0; ack1 = '0; a1 = '0; b1 = '0;
        v3 = '0; ack3 = '0; a3 = '0; b3 = '0;
        edge_n = 0;
        for (int i = 0; i < NR; i++) begin ia[i] = 0; ib[i] = 0; end
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_hold();
        test_wrap();
        test_reset_mid();
        test_lat3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
